// File: rtl/bin2digit_tx.sv
// Binary-to-BCD converter (iterative double-dabble, one bit per clock) that then
// streams the decimal digits most-significant first over a valid/ready handshake.
module bin2digit_tx #(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 5,
  parameter int SUPPRESS_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            digit,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic                  digit_last,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  bcd_nxt;
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  idx_dec;

  function automatic logic [3:0] nib_at(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] i);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (i == IDX_W'(k)) r = b[4*k +: 4];
    return r;
  endfunction

  // One double-dabble step: +3 on digits >= 5, then shift the operand MSB in.
  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    bcd_nxt = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
  end

  // First digit to send is chosen from the final BCD value of the last iteration.
  always_comb begin
    first_idx = '0;
    if (SUPPRESS_LZ == 0) first_idx = IDX_W'(DIGITS - 1);
    else
      for (int k = 0; k < DIGITS; k++)
        if (bcd_nxt[4*k +: 4] != 4'd0) first_idx = IDX_W'(k);
  end

  assign idx_dec   = idx_q - 1'b1;
  assign fsm_state = state_q;

  // Handshake: a digit moves on any cycle with digit_valid && digit_ready; while
  // ready is low digit/digit_last hold and valid stays high until the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      bcd         <= '0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      digit_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= value;
            bcd     <= '0;
            cnt_q   <= CNT_W'(DATA_W);
            busy    <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= bcd_nxt;
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= SEND;
            idx_q       <= first_idx;
            digit       <= nib_at(bcd_nxt, first_idx);
            digit_valid <= 1'b1;
            digit_last  <= (first_idx == '0);
          end
        end
        SEND: begin
          if (digit_ready) begin
            if (digit_last) begin
              state_q     <= IDLE;
              busy        <= 1'b0;
              digit       <= 4'd0;
              digit_valid <= 1'b0;
              digit_last  <= 1'b0;
              done        <= 1'b1;
            end else begin
              idx_q      <= idx_dec;
              digit      <= nib_at(bcd, idx_dec);
              digit_last <= (idx_dec == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2digit_tx.sv
// Directed bench for bin2digit_tx: one instance without and one with leading-zero
// suppression; expected digit streams and cycle counts are hand-computed.
module tb_bin2digit_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, rdy_a, rdy_b;
  logic [15:0] value;

  logic        a_busy, a_valid, a_last, a_done;
  logic [19:0] a_bcd;
  logic [3:0]  a_digit;
  logic [1:0]  a_state;
  logic        b_busy, b_valid, b_last, b_done;
  logic [19:0] b_bcd;
  logic [3:0]  b_digit;
  logic [1:0]  b_state;

  int errors = 0;
  int checks = 0;

  logic [3:0] got_q[$];
  logic       last_q[$];
  logic [3:0] hold_q[$];
  int         done_n;
  logic [19:0] seq;
  logic [4:0]  lastbits;

  always #5 clk = ~clk;

  bin2digit_tx dut_a (
    .clk(clk), .rst(rst), .start(start_a), .value(value), .busy(a_busy), .bcd(a_bcd),
    .digit(a_digit), .digit_valid(a_valid), .digit_ready(rdy_a), .digit_last(a_last),
    .done(a_done), .fsm_state(a_state)
  );

  bin2digit_tx #(.SUPPRESS_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .value(value), .busy(b_busy), .bcd(b_bcd),
    .digit(b_digit), .digit_valid(b_valid), .digit_ready(rdy_b), .digit_last(b_last),
    .done(b_done), .fsm_state(b_state)
  );

  // Called at a falling edge; the next rising edge (E0) accepts the start.
  task automatic do_start(input int which, input logic [15:0] v);
    value = v;
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // n counts rising edges since E0; observation at n is the state after E(n).
  task automatic collect(input int which, input int n0, input int budget, input int stall_pos,
                         input int stall_len, input int poke_n, input logic [15:0] poke_v);
    int n, left;
    logic v, l, dn, r;
    logic [3:0] d;
    got_q.delete(); last_q.delete(); hold_q.delete();
    done_n = -1;
    n = n0;
    left = stall_len;
    while (done_n < 0 && n < budget) begin
      v  = (which != 0) ? b_valid : a_valid;
      d  = (which != 0) ? b_digit : a_digit;
      l  = (which != 0) ? b_last  : a_last;
      dn = (which != 0) ? b_done  : a_done;
      if (dn) done_n = n;
      else begin
        r = 1'b1;
        if (v && got_q.size() == stall_pos && left > 0) begin
          r = 1'b0;
          left--;
          hold_q.push_back(d);
        end
        if (which != 0) rdy_b = r; else rdy_a = r;
        if (n == poke_n) begin
          value = poke_v;
          if (which != 0) start_b = 1'b1; else start_a = 1'b1;
        end else begin
          start_a = 1'b0;
          start_b = 1'b0;
        end
        if (v && r) begin
          got_q.push_back(d);
          last_q.push_back(l);
        end
        @(negedge clk);
        n++;
      end
    end
    rdy_a = 1'b1; rdy_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic pack_stream();
    seq = '0;
    lastbits = '0;
    foreach (got_q[i]) begin
      seq      = {seq[15:0], got_q[i]};
      lastbits = {lastbits[3:0], last_q[i]};
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; value = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({a_busy, a_bcd, a_digit, a_valid, a_last, a_done, a_state} !== 30'd0) begin
      errors++; $display("FAIL reset_a: got busy=%b bcd=%h valid=%b state=%0d, want all 0", a_busy, a_bcd, a_valid, a_state);
    end
    checks++;
    if ({b_busy, b_bcd, b_digit, b_valid, b_last, b_done, b_state} !== 30'd0) begin
      errors++; $display("FAIL reset_b: got busy=%b bcd=%h valid=%b state=%0d, want all 0", b_busy, b_bcd, b_valid, b_state);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_255();
    do_start(0, 16'd255);
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_after_e0: got %b want 1", a_busy); end
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL 255_count: got %0d want 5", got_q.size()); end
    checks++;
    if (seq !== 20'h00255) begin errors++; $display("FAIL 255_digits: got %h want 00255", seq); end
    checks++;
    if (lastbits !== 5'b00001) begin errors++; $display("FAIL 255_last: got %b want 00001", lastbits); end
    checks++;
    if (a_bcd !== 20'h00255) begin errors++; $display("FAIL 255_bcd: got %h want 00255", a_bcd); end
    checks++;
    if (done_n != 21) begin errors++; $display("FAIL 255_done_edge: got %0d want 21", done_n); end
    checks++;
    if ({a_busy, a_valid} !== 2'b00) begin errors++; $display("FAIL 255_idle_at_done: got busy=%b valid=%b want 0 0", a_busy, a_valid); end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin errors++; $display("FAIL 255_done_pulse: got %b want 0", a_done); end
  endtask

  task automatic test_values();
    do_start(0, 16'd65535);
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (seq !== 20'h65535) begin errors++; $display("FAIL 65535_digits: got %h want 65535", seq); end
    checks++;
    if (a_bcd !== 20'h65535) begin errors++; $display("FAIL 65535_bcd: got %h want 65535", a_bcd); end
    @(negedge clk);
    do_start(0, 16'd1);
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    checks++;
    if (a_bcd !== 20'h00001) begin errors++; $display("FAIL 1_bcd: got %h want 00001", a_bcd); end
    @(negedge clk);
    do_start(0, 16'd40960);
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    checks++;
    if (a_bcd !== 20'h40960) begin errors++; $display("FAIL 40960_bcd: got %h want 40960", a_bcd); end
    checks++;
    if (done_n != 21) begin errors++; $display("FAIL 40960_done_edge: got %0d want 21", done_n); end
    @(negedge clk);
  endtask

  task automatic test_suppress();
    do_start(1, 16'd0);
    collect(1, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL lz0_count: got %0d want 1", got_q.size()); end
    checks++;
    if ({seq[3:0], lastbits[0]} !== 5'b0000_1) begin errors++; $display("FAIL lz0_digit: got digit=%h last=%b want 0 1", seq[3:0], lastbits[0]); end
    checks++;
    if (done_n != 17) begin errors++; $display("FAIL lz0_done_edge: got %0d want 17", done_n); end
    @(negedge clk);
    do_start(1, 16'd907);
    collect(1, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL lz907_count: got %0d want 3", got_q.size()); end
    checks++;
    if (seq[11:0] !== 12'h907) begin errors++; $display("FAIL lz907_digits: got %h want 907", seq[11:0]); end
    checks++;
    if (lastbits[2:0] !== 3'b001) begin errors++; $display("FAIL lz907_last: got %b want 001", lastbits[2:0]); end
    checks++;
    if (done_n != 19) begin errors++; $display("FAIL lz907_done_edge: got %0d want 19", done_n); end
    checks++;
    if (b_bcd !== 20'h00907) begin errors++; $display("FAIL lz907_bcd: got %h want 00907", b_bcd); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_start(0, 16'd1234);
    collect(0, 0, 60, 1, 3, -1, 16'd0);
    pack_stream();
    checks++;
    if (hold_q.size() != 3) begin errors++; $display("FAIL bp_hold_cycles: got %0d want 3", hold_q.size()); end
    foreach (hold_q[i]) begin
      checks++;
      if (hold_q[i] !== 4'd1) begin errors++; $display("FAIL bp_hold_digit[%0d]: got %h want 1", i, hold_q[i]); end
    end
    checks++;
    if (got_q.size() != 5 || seq !== 20'h01234) begin errors++; $display("FAIL bp_stream: got %0d digits %h want 5 digits 01234", got_q.size(), seq); end
    checks++;
    if (done_n != 24) begin errors++; $display("FAIL bp_done_edge: got %0d want 24", done_n); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    do_start(0, 16'd1234);
    repeat (3) @(negedge clk);
    value = 16'd999;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    collect(0, 4, 60, -1, 0, 18, 16'd777);
    pack_stream();
    checks++;
    if (seq !== 20'h01234) begin errors++; $display("FAIL busy_start_digits: got %h want 01234", seq); end
    checks++;
    if (a_bcd !== 20'h01234) begin errors++; $display("FAIL busy_start_bcd: got %h want 01234", a_bcd); end
    checks++;
    if (done_n != 21) begin errors++; $display("FAIL busy_start_done_edge: got %0d want 21", done_n); end
  endtask

  task automatic test_back_to_back();
    do_start(0, 16'd65535);
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", a_busy); end
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (seq !== 20'h65535) begin errors++; $display("FAIL b2b_digits: got %h want 65535", seq); end
    checks++;
    if (done_n != 21) begin errors++; $display("FAIL b2b_done_edge: got %0d want 21", done_n); end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue: got busy=%b want 0", a_busy); end
  endtask

  task automatic test_reset_mid_send();
    do_start(0, 16'd4321);
    collect(0, 0, 18, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (got_q.size() != 2 || seq[7:0] !== 8'h04) begin errors++; $display("FAIL rst_partial: got %0d digits %h want 2 digits 04", got_q.size(), seq[7:0]); end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_bcd, a_digit, a_valid, a_last, a_done, a_state} !== 30'd0) begin
      errors++; $display("FAIL rst_mid_send: got busy=%b bcd=%h valid=%b state=%0d want all 0", a_busy, a_bcd, a_valid, a_state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_done, a_busy, a_state} !== 4'd0) begin errors++; $display("FAIL rst_no_done: got done=%b busy=%b state=%0d want 0", a_done, a_busy, a_state); end
    do_start(0, 16'd321);
    collect(0, 0, 60, -1, 0, -1, 16'd0);
    pack_stream();
    checks++;
    if (seq !== 20'h00321 || a_bcd !== 20'h00321) begin errors++; $display("FAIL rst_reconvert: got digits %h bcd %h want 00321", seq, a_bcd); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_255();
    test_values();
    test_suppress();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
